// File: rtl/jtframe_debug_pkg.sv
// Shared constants for the debug overlay scheduler: mode encoding and source width.
package jtframe_debug_pkg;

  localparam int DBG_W = 8;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

endpackage

// File: rtl/jtframe_debug_nextsrc.sv
// Wrap-around priority search for the nearest valid debug source above (dir=0)
// or below (dir=1) the current index; the current index itself is tried last.
module jtframe_debug_nextsrc #(
  parameter int NSRC = 4,
  parameter int IDXW = 2
) (
  input  logic [IDXW-1:0] idx,
  input  logic [NSRC-1:0] src_valid,
  input  logic            dir,
  output logic [IDXW-1:0] found_idx,
  output logic            found
);

  int j;

  always_comb begin
    found     = 1'b0;
    found_idx = idx;
    j         = 0;
    for (int k = 1; k <= NSRC; k++) begin
      j = dir ? (int'(idx) + NSRC - k) % NSRC : (int'(idx) + k) % NSRC;
      if (!found && src_valid[j[IDXW-1:0]]) begin
        found     = 1'b1;
        found_idx = j[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/jtframe_debug_sched.sv
// Shares the 8-bit debug_view overlay channel between NSRC probes, stepping
// manually or every FRAMES frames. Optional `freeze` input via JTFRAME_DEBUG_FREEZE_EN.
module jtframe_debug_sched
  import jtframe_debug_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int IDXW   = 2,
  parameter int FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lvbl,
  input  logic                  key_next,
  input  logic                  key_prev,
  input  logic                  key_auto,
`ifdef JTFRAME_DEBUG_FREEZE_EN
  input  logic                  freeze,
`endif
  input  logic [NSRC-1:0]       src_valid,
  input  logic [NSRC*DBG_W-1:0] src_data,
  output logic [DBG_W-1:0]      view_out,
  output logic [IDXW-1:0]       view_idx,
  output logic                  auto_on,
  output logic                  none_valid
);

  logic             next_q, prev_q, auto_q, lvbl_q;
  state_e           state_q;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [DBG_W-1:0] view_q, view_d;
  logic             none_q;
  logic             freeze_w;

`ifdef JTFRAME_DEBUG_FREEZE_EN
  assign freeze_w = freeze;
`else
  assign freeze_w = 1'b0;
`endif

  logic            ev_next, ev_prev, ev_auto, ev_vb;
  logic            man_next, man_prev, man_any;
  logic            none_w, cnt_wrap, auto_step, inval_step, in_auto;
  logic [IDXW-1:0] nxt_idx, prv_idx;
  logic            nxt_found, prv_found;

  assign ev_next    = key_next & ~next_q;
  assign ev_prev    = key_prev & ~prev_q;
  assign ev_auto    = key_auto & ~auto_q;
  assign ev_vb      = ~lvbl & lvbl_q;
  // Simultaneous next and prev cancel each other out
  assign man_next   = ev_next & ~ev_prev;
  assign man_prev   = ev_prev & ~ev_next;
  assign man_any    = man_next | man_prev;
  assign none_w     = ~|src_valid;
  assign in_auto    = (state_q == ST_AUTO);
  assign cnt_wrap   = (cnt_q == 8'(FRAMES - 1));
  assign auto_step  = in_auto & ev_vb & ~freeze_w & cnt_wrap;
  assign inval_step = ev_vb & ~src_valid[idx_q];

  jtframe_debug_nextsrc #(.NSRC(NSRC), .IDXW(IDXW)) u_next (
    .idx(idx_q), .src_valid(src_valid), .dir(1'b0),
    .found_idx(nxt_idx), .found(nxt_found)
  );

  jtframe_debug_nextsrc #(.NSRC(NSRC), .IDXW(IDXW)) u_prev (
    .idx(idx_q), .src_valid(src_valid), .dir(1'b1),
    .found_idx(prv_idx), .found(prv_found)
  );

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    view_d = view_q;
    // A manual key always wins over an automatic or invalid-source step
    if (man_next) begin
      if (nxt_found) idx_d = nxt_idx;
    end else if (man_prev) begin
      if (prv_found) idx_d = prv_idx;
    end else if ((auto_step | inval_step) && nxt_found) begin
      idx_d = nxt_idx;
    end
    if (ev_auto || (in_auto && man_any)) begin
      cnt_d = 8'd0;
    end else if (in_auto && ev_vb && !freeze_w) begin
      cnt_d = cnt_wrap ? 8'd0 : cnt_q + 8'd1;
    end
    if (ev_vb && !freeze_w) begin
      view_d = none_w ? '0 : src_data[int'(idx_q)*DBG_W +: DBG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q  <= 1'b0;
      prev_q  <= 1'b0;
      auto_q  <= 1'b0;
      lvbl_q  <= 1'b0;
      state_q <= ST_MANUAL;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      view_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      next_q  <= key_next;
      prev_q  <= key_prev;
      auto_q  <= key_auto;
      lvbl_q  <= lvbl;
      if (ev_auto) state_q <= in_auto ? ST_MANUAL : ST_AUTO;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      view_q  <= view_d;
      none_q  <= none_w;
    end
  end

  assign view_out   = view_q;
  assign view_idx   = idx_q;
  assign auto_on    = (state_q == ST_AUTO);
  assign none_valid = none_q;

endmodule

// File: tb/tb_jtframe_debug_sched.sv
// Directed self-checking bench for jtframe_debug_sched (NSRC=4, FRAMES=3);
// the freeze steps only exist when JTFRAME_DEBUG_FREEZE_EN is defined.
module tb_jtframe_debug_sched;

  localparam int NSRC   = 4;
  localparam int IDXW   = 2;
  localparam int FRAMES = 3;

  logic        clk = 1'b0;
  logic        rst_n, lvbl, key_next, key_prev, key_auto, freeze;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  wire  [7:0]  view_out;
  wire  [1:0]  view_idx;
  wire         auto_on, none_valid;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtframe_debug_sched #(.NSRC(NSRC), .IDXW(IDXW), .FRAMES(FRAMES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lvbl(lvbl),
    .key_next(key_next),
    .key_prev(key_prev),
    .key_auto(key_auto),
`ifdef JTFRAME_DEBUG_FREEZE_EN
    .freeze(freeze),
`endif
    .src_valid(src_valid),
    .src_data(src_data),
    .view_out(view_out),
    .view_idx(view_idx),
    .auto_on(auto_on),
    .none_valid(none_valid)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse any combination of keys for two cycles, then release them
  task automatic applyStimulus(input logic nxt, input logic prv, input logic aut);
    key_next = nxt;
    key_prev = prv;
    key_auto = aut;
    tick(2);
    key_next = 1'b0;
    key_prev = 1'b0;
    key_auto = 1'b0;
    tick(2);
  endtask

  task automatic vblank();
    lvbl = 1'b0;
    tick(2);
    lvbl = 1'b1;
    tick(2);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    lvbl      = 1'b1;
    key_next  = 1'b0;
    key_prev  = 1'b0;
    key_auto  = 1'b0;
    freeze    = 1'b0;
    src_valid = 4'b0000;
    src_data  = 32'h0;
    tick(3);
    checkOutput("rst_view", view_out, 8'h00);
    checkOutput("rst_idx", {6'd0, view_idx}, 8'd0);
    checkOutput("rst_auto", {7'd0, auto_on}, 8'd0);
    checkOutput("rst_none", {7'd0, none_valid}, 8'd0);

    rst_n     = 1'b1;
    src_valid = 4'b1111;
    src_data  = 32'h13121110;
    tick(2);
    vblank();
    checkOutput("first_view", view_out, 8'h10);
    checkOutput("first_idx", {6'd0, view_idx}, 8'd0);
    checkOutput("first_auto", {7'd0, auto_on}, 8'd0);

    src_valid = 4'b1011;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("man_next_1", {6'd0, view_idx}, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("man_next_skip", {6'd0, view_idx}, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("man_next_wrap", {6'd0, view_idx}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("man_prev_wrap", {6'd0, view_idx}, 8'd3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("man_both", {6'd0, view_idx}, 8'd3);

    src_valid = 4'b1111;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("man_to_0", {6'd0, view_idx}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("auto_on", {7'd0, auto_on}, 8'd1);

    // Step every third vblank; view shows the source selected before the step
    for (int n = 1; n <= 18; n++) begin
      vblank();
      checkOutput($sformatf("auto_idx_%0d", n), {6'd0, view_idx}, 8'((n / FRAMES) % NSRC));
      checkOutput($sformatf("auto_view_%0d", n), view_out, 8'(8'h10 + ((n - 1) / FRAMES) % NSRC));
    end

    src_data[23:16] = 8'hA5;
    tick(3);
    checkOutput("midframe_hold", view_out, 8'h11);
    src_data[23:16] = 8'h12;

    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_view", view_out, 8'h00);
    checkOutput("async_idx", {6'd0, view_idx}, 8'd0);
    checkOutput("async_auto", {7'd0, auto_on}, 8'd0);
    rst_n = 1'b1;
    tick(2);
    vblank();
    vblank();
    vblank();
    checkOutput("post_rst_manual", {7'd0, auto_on}, 8'd0);
    checkOutput("post_rst_idx", {6'd0, view_idx}, 8'd0);
    checkOutput("post_rst_view", view_out, 8'h10);

    src_valid = 4'b0000;
    tick(2);
    checkOutput("none_flag", {7'd0, none_valid}, 8'd1);
    vblank();
    checkOutput("none_view", view_out, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("none_key", {6'd0, view_idx}, 8'd0);
    src_valid = 4'b1111;
    tick(2);
    checkOutput("none_clear", {7'd0, none_valid}, 8'd0);

    src_valid = 4'b1110;
    tick(1);
    vblank();
    checkOutput("inval_idx", {6'd0, view_idx}, 8'd1);
    checkOutput("inval_view", view_out, 8'h10);
    src_valid = 4'b1111;

    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("combo_auto", {7'd0, auto_on}, 8'd1);
    checkOutput("combo_idx", {6'd0, view_idx}, 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("back_manual", {7'd0, auto_on}, 8'd0);

`ifdef JTFRAME_DEBUG_FREEZE_EN
    vblank();
    checkOutput("frz_pre", view_out, 8'h12);
    freeze = 1'b1;
    src_data[23:16] = 8'h77;
    src_data[31:24] = 8'h88;
    vblank();
    checkOutput("frz_hold1", view_out, 8'h12);
    vblank();
    checkOutput("frz_hold2", view_out, 8'h12);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("frz_key_idx", {6'd0, view_idx}, 8'd3);
    freeze = 1'b0;
    tick(2);
    checkOutput("frz_release_wait", view_out, 8'h12);
    vblank();
    checkOutput("frz_release_load", view_out, 8'h88);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
